lcd_serial_ctrl: RTL
====================

LCD_SERIAL_CTRL -- requirements
Module: lcd_serial_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bits per LCD serial frame; legal range 2..32.
REQ-002 Parameter DIV_RESET, default 4: reset value of the DIV register, 8 bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 address  input  2  Avalon-MM word address: 0=DATA, 1=STATUS, 2=DIV, 3=reserved.
REQ-006 chipselect  input  1  slave select; a write requires chipselect=1 and write_n=0.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  combinational read mux of the addressed register, zero-extended; 0 for address 3.
REQ-010 lcd_clk  output  1  serial clock to the LCD, idles low.
REQ-011 lcd_data  output  1  serial data, MSB first, changes only while lcd_clk is low.
REQ-012 lcd_cs_n  output  1  active-low frame select, idles high.

Function
REQ-013 Half-period H = DIV+1 clk cycles; DIV=0 gives H=1.
REQ-014 FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD; a counter timing H runs in every state except IDLE.
REQ-015 A DATA write in IDLE loads writedata[DATA_WIDTH-1:0] into the shift register and, on the next cycle, sets lcd_cs_n=0, lcd_data=MSB, busy=1 and enters SETUP.
REQ-016 SETUP lasts H cycles with lcd_clk=0, then enters SHIFT_HI.
REQ-017 SHIFT_HI drives lcd_clk=1 for H cycles, then enters SHIFT_LO.
REQ-018 SHIFT_LO drives lcd_clk=0 for H cycles; on entry, lcd_data advances to the next bit; after DATA_WIDTH high phases it enters HOLD instead.
REQ-019 HOLD lasts H cycles with lcd_clk=0 and the last bit held, then lcd_cs_n=1, busy=0, done=1, back to IDLE.
REQ-020 Frame length from lcd_cs_n fall to rise = (2*DATA_WIDTH+2)*H cycles.
REQ-021 STATUS read: bit0 busy, bit1 done (sticky), bit2 overrun (sticky), others 0.
REQ-022 A write to STATUS with writedata[1]=1 clears done; writedata[2]=1 clears overrun (write-1-to-clear).
REQ-023 A DATA write while busy is discarded, the frame in flight is unaffected, and overrun is set.
REQ-024 A DIV write takes effect at the next H-counter reload; a DIV write during a frame does not corrupt bit order.
REQ-025 If a DATA write and done completion occur in the same cycle, the write is treated as busy (overrun) and done is still set.
REQ-026 A simultaneous STATUS clear and set of the same sticky bit leaves it set.
REQ-027 DATA reads return the last written value, masked to DATA_WIDTH bits.

Reset
REQ-028 Reset forces IDLE, lcd_clk=0, lcd_data=0, lcd_cs_n=1, busy=done=overrun=0, DATA=0, DIV=DIV_RESET.
REQ-029 Reset asserted mid-frame aborts the frame in the same edge: lcd_cs_n=1 next cycle, done not set.

Configuration
REQ-030 Macro LCD_SERIAL_CTRL_IRQ_EN: when defined, add output irq (1 bit) plus register address 3 CTRL, bit0 irq_en (reset 0); irq = irq_en & (done | overrun). Without the macro, there is no irq port and address 3 reads 0 and ignores writes.

Verification
REQ-031 DIV=0, write DATA=0xA5C3 -> lcd_cs_n low for 34 cycles, 16 lcd_clk pulses of 1 cycle each, sampled bits 1010010111000011, then done=1 and busy=0.
REQ-032 DIV=3, write 0x0001 -> H=4, frame lasts 136 cycles, lcd_data high only in the 16th bit.
REQ-033 Write 0x1234 then 0xFFFF while busy -> LCD receives 0x1234, overrun=1; STATUS write 0x6 clears done and overrun to 0.
REQ-034 Assert reset during bit 7 -> next cycle lcd_cs_n=1, lcd_clk=0, STATUS=0, DIV=4.
REQ-035 Change DIV from 1 to 5 mid-frame -> all 16 bits are received correctly and later half-periods are 6 cycles.
REQ-036 With LCD_SERIAL_CTRL_IRQ_EN defined: CTRL=1, complete a frame -> irq=1; clearing done -> irq=0.

Source files
------------

// File: rtl/lcd_serial_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_serial_ctrl
// Avalon-MM slave that shifts a DATA_WIDTH-bit word out to a serial LCD,
// MSB first, with a programmable half-period of DIV+1 clk cycles.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   address[1:0]          0=DATA, 1=STATUS, 2=DIV, 3=CTRL (irq build) / reserved
//   chipselect, write_n   a write needs chipselect=1 and write_n=0
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read mux, zero-extended
//   irq                   only with LCD_SERIAL_CTRL_IRQ_EN: irq_en & (done|overrun)
//   lcd_clk               serial clock, idles low
//   lcd_data              serial data, changes only while lcd_clk is low
//   lcd_cs_n              active-low frame select, idles high
//
// Optional feature macro: LCD_SERIAL_CTRL_IRQ_EN adds the irq output and the
// CTRL register at address 3 (bit0 irq_en).
// ---------------------------------------------------------------------------
module lcd_serial_ctrl #(
   parameter int         DATA_WIDTH = 16,
   parameter logic [7:0] DIV_RESET  = 8'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
`ifdef LCD_SERIAL_CTRL_IRQ_EN
   output logic        irq,
`endif
   output logic        lcd_clk,
   output logic        lcd_data,
   output logic        lcd_cs_n
);

   localparam logic [5:0] NUM_BITS = 6'(DATA_WIDTH);
   localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   data_reg;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic [7:0]              div_reg;
   logic [7:0]              h_cnt;
   logic [5:0]              bit_cnt;
   logic                    busy;
   logic                    done;
   logic                    overrun;

   logic wr_en;
   logic data_wr;
   logic start;
   logic done_set;
   logic overrun_set;
   logic clr_done;
   logic clr_overrun;

`ifdef LCD_SERIAL_CTRL_IRQ_EN
   logic irq_en;
`endif

   // Upper writedata bits are only meaningful for some registers/widths.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   // Bus decode and sticky-bit events. A DATA write is only accepted in IDLE;
   // anything else (including the HOLD->IDLE completion cycle) is an overrun.
   always_comb begin
      wr_en       = chipselect & ~write_n;
      data_wr     = wr_en && (address == 2'd0);
      start       = data_wr && (state == IDLE);
      overrun_set = data_wr && (state != IDLE);
      done_set    = (state == HOLD) && (h_cnt == 8'd0);
      clr_done    = wr_en && (address == 2'd1) && writedata[1];
      clr_overrun = wr_en && (address == 2'd1) && writedata[2];
   end

   // Register read mux; unused upper bits read as zero.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[DATA_WIDTH-1:0] = data_reg;
         2'd1:    readdata[2:0]            = {overrun, done, busy};
         2'd2:    readdata[7:0]            = div_reg;
`ifdef LCD_SERIAL_CTRL_IRQ_EN
         default: readdata[0]              = irq_en;
`else
         default: readdata                 = '0;
`endif
      endcase
   end

`ifdef LCD_SERIAL_CTRL_IRQ_EN
   assign irq = irq_en & (done | overrun);
`endif

   // Frame sequencer. Every non-IDLE state lasts DIV+1 cycles, timed by h_cnt,
   // which reloads from div_reg at each phase change so a DIV write lands
   // cleanly on the next phase boundary. Sticky bits give set priority over
   // a simultaneous write-1-to-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_reg  <= '0;
         shift_reg <= '0;
         div_reg   <= DIV_RESET;
         h_cnt     <= '0;
         bit_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         lcd_clk   <= 1'b0;
         lcd_data  <= 1'b0;
         lcd_cs_n  <= 1'b1;
`ifdef LCD_SERIAL_CTRL_IRQ_EN
         irq_en    <= 1'b0;
`endif
      end else begin
         if (wr_en && (address == 2'd2))
            div_reg <= writedata[7:0];
`ifdef LCD_SERIAL_CTRL_IRQ_EN
         if (wr_en && (address == 2'd3))
            irq_en <= writedata[0];
`endif
         done    <= done_set    | (done    & ~clr_done);
         overrun <= overrun_set | (overrun & ~clr_overrun);

         case (state)
            IDLE: begin
               if (start) begin
                  data_reg  <= writedata[DATA_WIDTH-1:0];
                  shift_reg <= writedata[DATA_WIDTH-1:0];
                  lcd_data  <= writedata[DATA_WIDTH-1];
                  lcd_cs_n  <= 1'b0;
                  busy      <= 1'b1;
                  h_cnt     <= div_reg;
                  bit_cnt   <= '0;
                  state     <= SETUP;
               end
            end
            default: begin
               if (h_cnt != 8'd0) begin
                  h_cnt <= h_cnt - 8'd1;
               end else begin
                  h_cnt <= div_reg;
                  case (state)
                     SETUP: begin
                        lcd_clk <= 1'b1;
                        state   <= SHIFT_HI;
                     end
                     SHIFT_HI: begin
                        // Falling edge: present the next bit unless the last
                        // one is already on the line.
                        lcd_clk <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt != LAST_BIT) begin
                           lcd_data  <= shift_reg[DATA_WIDTH-2];
                           shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                        state <= SHIFT_LO;
                     end
                     SHIFT_LO: begin
                        if (bit_cnt == NUM_BITS) begin
                           state <= HOLD;
                        end else begin
                           lcd_clk <= 1'b1;
                           state   <= SHIFT_HI;
                        end
                     end
                     HOLD: begin
                        lcd_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
